// File: rtl/chart_seq.sv
// rtl/chart_seq.sv - timestamped note chart sequencer emitting per-track spawn pulses
module chart_seq #(
    parameter int NUM_TRACKS  = 4,
    parameter int CHART_DEPTH = 64,
    parameter int TIME_W      = 32,
    parameter int LEAD_MS     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [TIME_W-1:0]              i_cur_time,
    input  logic                           i_wr_en,
    input  logic [$clog2(CHART_DEPTH)-1:0] i_wr_addr,
    input  logic [TIME_W-1:0]              i_wr_time,
    input  logic [NUM_TRACKS-1:0]          i_wr_mask,
    input  logic [$clog2(CHART_DEPTH):0]   i_note_count,
    input  logic                           i_start,
    input  logic                           i_pause,
    input  logic                           i_stop,
    output logic [NUM_TRACKS-1:0]          o_note,
    output logic [$clog2(CHART_DEPTH):0]   o_note_idx,
    output logic                           o_busy,
    output logic                           o_game_end,
    output logic                           o_wr_err
);
    localparam int AW = $clog2(CHART_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TIME_W-1:0]     r_time [CHART_DEPTH];
    logic [NUM_TRACKS-1:0] r_mask [CHART_DEPTH];
    logic [CW-1:0]         r_idx;
    logic [CW-1:0]         r_count;
    logic [NUM_TRACKS-1:0] r_note;
    logic                  r_wr_err;

    logic                  w_wr_ok;
    logic                  w_due;
    logic                  w_consume;
    logic                  w_load;
    logic [TIME_W:0]       w_lead_time;
    logic [CW-1:0]         w_count_clamped;

    // One extra bit so a lead-in near the top of the time range cannot wrap.
    assign w_lead_time     = {1'b0, i_cur_time} + (TIME_W+1)'(LEAD_MS);
    assign w_due           = w_lead_time >= {1'b0, r_time[r_idx[AW-1:0]]};
    assign w_wr_ok         = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_count_clamped = (i_note_count > CW'(CHART_DEPTH)) ? CW'(CHART_DEPTH) : i_note_count;

    always_comb begin
        w_state_nxt = r_state;
        w_consume   = 1'b0;
        w_load      = 1'b0;
        if (i_stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_pause) begin
                        w_state_nxt = S_PAUSE;
                    end else if (r_idx == r_count) begin
                        w_state_nxt = S_DONE;
                    end else if (w_due) begin
                        w_consume = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (!i_pause) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_count  <= '0;
            r_note   <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_note   <= w_consume ? r_mask[r_idx[AW-1:0]] : '0;
            r_wr_err <= i_wr_en && !w_wr_ok;
            if (i_stop) begin
                r_idx <= '0;
            end else if (w_load) begin
                r_idx   <= '0;
                r_count <= w_count_clamped;
            end else if (w_consume) begin
                r_idx <= r_idx + CW'(1);
            end
        end
    end

    // Chart memory is deliberately not reset so a loaded chart survives reset and replays.
    always_ff @(posedge clk) begin
        if (i_wr_en && w_wr_ok) begin
            r_time[i_wr_addr] <= i_wr_time;
            r_mask[i_wr_addr] <= i_wr_mask;
        end
    end

    assign o_note     = r_note;
    assign o_note_idx = r_idx;
    assign o_busy     = (r_state == S_RUN) || (r_state == S_PAUSE);
    assign o_game_end = (r_state == S_DONE);
    assign o_wr_err   = r_wr_err;
endmodule

// File: tb/tb_chart_seq.sv
// tb/tb_chart_seq.sv - randomized and directed checks of chart_seq against a chart playback model
module tb_chart_seq;
    localparam int NT    = 4;
    localparam int DEPTH = 8;
    localparam int TW    = 16;
    localparam int AW    = 3;
    localparam int CW    = 4;

    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;
    localparam int ST_DONE  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [TW-1:0] cur_time;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [TW-1:0] wr_time;
    logic [NT-1:0] wr_mask;
    logic [CW-1:0] note_count;
    logic          start, pause, stop;

    logic [NT-1:0] note [2];
    logic [CW-1:0] nidx [2];
    logic          busy [2];
    logic          gend [2];
    logic          werr [2];

    chart_seq #(.NUM_TRACKS(NT), .CHART_DEPTH(DEPTH), .TIME_W(TW), .LEAD_MS(0)) u_dut0 (
        .clk(clk), .rst(rst), .i_cur_time(cur_time), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_time(wr_time), .i_wr_mask(wr_mask), .i_note_count(note_count), .i_start(start),
        .i_pause(pause), .i_stop(stop), .o_note(note[0]), .o_note_idx(nidx[0]),
        .o_busy(busy[0]), .o_game_end(gend[0]), .o_wr_err(werr[0]));

    chart_seq #(.NUM_TRACKS(NT), .CHART_DEPTH(DEPTH), .TIME_W(TW), .LEAD_MS(500)) u_dut1 (
        .clk(clk), .rst(rst), .i_cur_time(cur_time), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_time(wr_time), .i_wr_mask(wr_mask), .i_note_count(note_count), .i_start(start),
        .i_pause(pause), .i_stop(stop), .o_note(note[1]), .o_note_idx(nidx[1]),
        .o_busy(busy[1]), .o_game_end(gend[1]), .o_wr_err(werr[1]));

    int leads [2] = '{0, 500};
    int m_state [2];
    int m_idx [2];
    int m_count [2];
    int m_note [2];
    int m_err [2];
    int m_time [2][DEPTH];
    int m_mask [2][DEPTH];
    int seen [$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Playback model: chart memory plus a play position advanced by the spec's rules.
    task automatic model_step(input int m);
        m_note[m] = 0;
        m_err[m]  = 0;
        if (rst) begin
            m_state[m] = ST_IDLE;
            m_idx[m]   = 0;
            m_count[m] = 0;
            return;
        end
        if (wr_en) begin
            if (m_state[m] == ST_IDLE || m_state[m] == ST_DONE) begin
                m_time[m][wr_addr] = int'(wr_time);
                m_mask[m][wr_addr] = int'(wr_mask);
            end else begin
                m_err[m] = 1;
            end
        end
        if (stop) begin
            m_state[m] = ST_IDLE;
            m_idx[m]   = 0;
        end else if (m_state[m] == ST_IDLE || m_state[m] == ST_DONE) begin
            if (start) begin
                m_count[m] = (int'(note_count) > DEPTH) ? DEPTH : int'(note_count);
                m_idx[m]   = 0;
                m_state[m] = ST_RUN;
            end
        end else if (m_state[m] == ST_RUN) begin
            if (pause) m_state[m] = ST_PAUSE;
            else if (m_idx[m] == m_count[m]) m_state[m] = ST_DONE;
            else if (int'(cur_time) + leads[m] >= m_time[m][m_idx[m]]) begin
                m_note[m] = m_mask[m][m_idx[m]];
                m_idx[m]  = m_idx[m] + 1;
            end
        end else begin
            if (!pause) m_state[m] = ST_RUN;
        end
    endtask

    task automatic cycle();
        for (int m = 0; m < 2; m++) model_step(m);
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("note%0d", m), note[m], m_note[m]);
            check($sformatf("idx%0d", m), nidx[m], m_idx[m]);
            check($sformatf("busy%0d", m), busy[m], (m_state[m] == ST_RUN || m_state[m] == ST_PAUSE));
            check($sformatf("game_end%0d", m), gend[m], (m_state[m] == ST_DONE));
            check($sformatf("wr_err%0d", m), werr[m], m_err[m]);
        end
        if (note[0] != 0) seen.push_back(int'(note[0]));
        wr_en = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic write_entry(input int a, input int t, input int mask);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_time = TW'(t);
        wr_mask = NT'(mask);
        cycle();
    endtask

    task automatic do_start(input int n);
        note_count = CW'(n);
        start      = 1'b1;
        cycle();
    endtask

    task automatic ramp(input int from, input int to, input int step);
        for (int t = from; t <= to; t += step) begin
            cur_time = TW'(t);
            cycle();
        end
    endtask

    function automatic int seen_at(input int i);
        return (i < seen.size()) ? seen[i] : -1;
    endfunction

    task automatic check_seq(input string tag);
        check({tag, "_len"}, seen.size(), 3);
        check({tag, "_0"}, seen_at(0), 1);
        check({tag, "_1"}, seen_at(1), 2);
        check({tag, "_2"}, seen_at(2), 15);
    endtask

    initial begin
        int tf0, tf1, r;
        rst = 1'b1; cur_time = '0; wr_en = 1'b0; wr_addr = '0; wr_time = '0; wr_mask = '0;
        note_count = '0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < DEPTH; i++) begin
                m_time[m][i] = 0;
                m_mask[m][i] = 0;
            end
        rst = 1'b1; cycle();
        rst = 1'b1; cycle();
        check("reset_busy", busy[0], 0);
        check("reset_game_end", gend[0], 0);
        for (int i = 0; i < DEPTH; i++) write_entry(i, 0, 0);

        // Basic chart with shared timestamp; LEAD_MS instance fires 500 ms early.
        write_entry(0, 1000, 1);
        write_entry(1, 2000, 2);
        write_entry(2, 2000, 15);
        cur_time = '0;
        do_start(3);
        seen.delete();
        tf0 = -1; tf1 = -1;
        for (int t = 0; t <= 2500; t += 10) begin
            cur_time = TW'(t);
            cycle();
            if (tf0 < 0 && note[0] != 0) tf0 = t;
            if (tf1 < 0 && note[1] != 0) tf1 = t;
        end
        check("first_pulse_time", tf0, 1000);
        check("lead_pulse_time", tf1, 500);
        check_seq("basic_seq");
        check("basic_done", gend[0], 1);

        // Pause while entry 1 becomes due.
        cur_time = '0;
        do_start(3);
        ramp(0, 1500, 10);
        pause = 1'b1;
        cycle();
        seen.delete();
        ramp(1510, 2500, 10);
        check("pause_quiet", seen.size(), 0);
        check("pause_idx", nidx[0], 1);
        pause = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("resume_first", seen_at(0), 2);
        check("resume_second", seen_at(1), 15);

        // Rejected write during playback leaves the chart intact.
        cur_time = '0;
        do_start(3);
        write_entry(1, 0, 8);
        check("wr_err_pulse", werr[0], 1);
        cycle();
        check("wr_err_clear", werr[0], 0);
        stop = 1'b1; cycle();
        seen.delete();
        do_start(3);
        ramp(0, 2500, 10);
        check_seq("after_wr_err_seq");

        // Empty chart.
        seen.delete();
        do_start(0);
        check("empty_not_done_yet", gend[0], 0);
        cycle();
        check("empty_done", gend[0], 1);
        check("empty_no_pulse", seen.size(), 0);

        // Reset mid-run, then replay.
        cur_time = '0;
        do_start(3);
        ramp(0, 1000, 10);
        rst = 1'b1; cycle();
        check("rst_busy", busy[0], 0);
        check("rst_idx", nidx[0], 0);
        seen.delete();
        ramp(1010, 2500, 10);
        check("rst_quiet", seen.size(), 0);
        do_start(3);
        ramp(0, 2500, 10);
        check_seq("rst_replay_seq");

        // Stop mid-run, then replay.
        cur_time = '0;
        do_start(3);
        ramp(0, 1000, 10);
        stop = 1'b1; cycle();
        check("stop_busy", busy[0], 0);
        seen.delete();
        ramp(1010, 2500, 10);
        check("stop_quiet", seen.size(), 0);
        do_start(3);
        ramp(0, 2500, 10);
        check_seq("stop_replay_seq");

        // Lead-in near the top of the time range must not wrap.
        write_entry(3, 65535, 8);
        cur_time = TW'(65100);
        do_start(4);
        for (int i = 0; i < 6; i++) cycle();
        cur_time = TW'(65535);
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                wr_en   = 1'b1;
                wr_addr = AW'($urandom_range(0, DEPTH - 1));
                wr_time = ($urandom_range(0, 9) == 0) ? TW'($urandom) : TW'($urandom_range(0, 3000));
                wr_mask = NT'($urandom);
            end else if (r < 13) begin
                start      = 1'b1;
                note_count = CW'($urandom_range(0, 15));
            end else if (r < 15) begin
                stop = 1'b1;
            end else if (r < 16) begin
                rst = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            if ($urandom_range(0, 9) == 0) cur_time = TW'($urandom);
            else cur_time = cur_time + TW'($urandom_range(0, 60));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
